palette_fade_lut: RTL and testbench

Parametrised, run-time-writable colour palette for the VGA pixel path. It is the successor to the fixed 32-entry map palettes.
- Maps a pixel index to {red, green, blue} through a registered 2-stage pipeline.
- Accepts palette writes from game logic over a valid/ready handshake.
- Contains a frame-synchronous fade engine that scales all output colour by a global brightness, used for screen transitions between maps.
- Sits between the sprite/map ROM address stage and the VGA colour outputs.

---
 rtl/palette_fade_lut.sv | 278 +++++++++++++++++++++++++++
 tb/tb_palette_fade_lut.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_fade_lut.sv
// palette_fade_lut: run-time-writable colour palette with a frame-synchronous
// brightness fade engine. Pixel index -> {r,g,b} through a 2-stage pipeline.
// Optional feature macro: PALETTE_DOUBLE_BUF_EN (active/shadow banks with
// vsync-aligned swap). Default build is a single bank with swap_i ignored.
module palette_fade_lut #(
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned CH_W     = 4,
   parameter int unsigned BRIGHT_W = 4,
   parameter logic [(2**IDX_W)*3*CH_W-1:0] INIT_PALETTE = '0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  pix_valid_i,
   input  logic [IDX_W-1:0]      pix_index_i,
   input  logic                  vsync_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [IDX_W-1:0]      wr_index_i,
   input  logic [3*CH_W-1:0]     wr_color_i,
   input  logic                  swap_i,
   input  logic                  fade_start_i,
   input  logic                  fade_dir_i,
   input  logic [3:0]            fade_rate_i,
   output logic [CH_W-1:0]       red_o,
   output logic [CH_W-1:0]       green_o,
   output logic [CH_W-1:0]       blue_o,
   output logic                  pix_valid_o,
   output logic                  fade_busy_o,
   output logic [BRIGHT_W:0]     brightness_o
);

   localparam int unsigned DEPTH = 2**IDX_W;
   localparam int unsigned COL_W = 3*CH_W;
   localparam int unsigned BR_W  = BRIGHT_W + 1;
   localparam logic [BR_W-1:0] BR_FULL = {1'b1, {BRIGHT_W{1'b0}}};
   localparam logic [BR_W-1:0] BR_ONE  = {{BRIGHT_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STEP} fade_state_e;

   // (c * b) >> BRIGHT_W in a CH_W+BRIGHT_W+1 bit product, truncated to CH_W
   function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                             input logic [BR_W-1:0] b);
      return CH_W'(({{BR_W{1'b0}}, c} * {{CH_W{1'b0}}, b}) >> BRIGHT_W);
   endfunction

   // fade engine state
   fade_state_e     state_q, state_d;
   logic [BR_W-1:0] bright_q, bright_d;
   logic            dir_q, dir_d;
   logic [3:0]      rate_q, rate_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            wr_ready_q, wr_ready_d;

   // read pipeline state
   logic [COL_W-1:0] s1_color_q, s1_color_d;
   logic [BR_W-1:0]  s1_bright_q, s1_bright_d;
   logic             s1_valid_q, s1_valid_d;
   logic [CH_W-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic             valid2_q, valid2_d;

   logic             wr_fire;
   logic [COL_W-1:0] rd_color;
   logic [BR_W-1:0]  start_target, target, bright_step;
   logic [3:0]       cnt_inc;

   assign wr_fire = wr_valid_i & wr_ready_q;

`ifdef PALETTE_DOUBLE_BUF_EN
   logic [COL_W-1:0] bank0_q [DEPTH];
   logic [COL_W-1:0] bank0_d [DEPTH];
   logic [COL_W-1:0] bank1_q [DEPTH];
   logic [COL_W-1:0] bank1_d [DEPTH];
   logic             active_q, active_d;
   logic             armed_q, armed_d;
   logic             copy_q, copy_d;
   logic [IDX_W-1:0] copy_idx_q, copy_idx_d;

   assign rd_color = active_q ? bank1_q[pix_index_i] : bank0_q[pix_index_i];

   // swap arming, vsync-aligned role exchange and shadow refresh sequencing
   always_comb begin
      active_d   = active_q;
      armed_d    = armed_q;
      copy_d     = copy_q;
      copy_idx_d = copy_idx_q;
      if (copy_q) begin
         copy_idx_d = copy_idx_q + 1'b1;
         if (copy_idx_q == '1) begin
            copy_d = 1'b0;
         end
      end else if (armed_q) begin
         if (vsync_i) begin
            active_d   = ~active_q;
            armed_d    = 1'b0;
            copy_d     = 1'b1;
            copy_idx_d = '0;
         end
      end else if (swap_i) begin
         armed_d = 1'b1;
      end
   end

   // shadow bank takes writes and, after a swap, one copied entry per cycle
   always_comb begin
      bank0_d = bank0_q;
      bank1_d = bank1_q;
      if (wr_fire) begin
         if (active_q) bank0_d[wr_index_i] = wr_color_i;
         else          bank1_d[wr_index_i] = wr_color_i;
      end
      if (copy_q) begin
         if (active_q) bank0_d[copy_idx_q] = bank1_q[copy_idx_q];
         else          bank1_d[copy_idx_q] = bank0_q[copy_idx_q];
      end
   end

   // bank storage and swap control registers
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank0_q[i] <= INIT_PALETTE[i*COL_W +: COL_W];
            bank1_q[i] <= INIT_PALETTE[i*COL_W +: COL_W];
         end
         active_q   <= 1'b0;
         armed_q    <= 1'b0;
         copy_q     <= 1'b0;
         copy_idx_q <= '0;
      end else begin
         bank0_q    <= bank0_d;
         bank1_q    <= bank1_d;
         active_q   <= active_d;
         armed_q    <= armed_d;
         copy_q     <= copy_d;
         copy_idx_q <= copy_idx_d;
      end
   end

   assign wr_ready_d = ~busy_d & ~armed_d & ~copy_d;
`else
   logic [COL_W-1:0] mem_q [DEPTH];
   logic [COL_W-1:0] mem_d [DEPTH];
   logic             unused_swap;

   assign unused_swap = swap_i;
   assign rd_color    = mem_q[pix_index_i];

   // apply an accepted write; reads in the same cycle still see mem_q
   always_comb begin
      mem_d = mem_q;
      if (wr_fire) begin
         mem_d[wr_index_i] = wr_color_i;
      end
   end

   // palette storage
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INIT_PALETTE[i*COL_W +: COL_W];
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign wr_ready_d = ~busy_d;
`endif

   // fade FSM next-state: IDLE -> WAIT (count vsyncs) -> STEP (one brightness step)
   always_comb begin
      state_d      = state_q;
      bright_d     = bright_q;
      dir_d        = dir_q;
      rate_d       = rate_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      start_target = fade_dir_i ? BR_FULL : '0;
      target       = dir_q ? BR_FULL : '0;
      bright_step  = dir_q ? (bright_q + BR_ONE) : (bright_q - BR_ONE);
      cnt_inc      = cnt_q + 4'd1;
      case (state_q)
         ST_IDLE: begin
            if (fade_start_i) begin
               dir_d  = fade_dir_i;
               rate_d = (fade_rate_i == 4'd0) ? 4'd1 : fade_rate_i;
               if (bright_q != start_target) begin
                  state_d = ST_WAIT;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (vsync_i) begin
               cnt_d = cnt_inc;
               if (cnt_inc == rate_q) begin
                  state_d = ST_STEP;
               end
            end
         end
         ST_STEP: begin
            cnt_d    = '0;
            bright_d = bright_step;
            if (bright_step == target) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // read pipeline next-state: stage 1 samples entry/brightness, stage 2 scales
   always_comb begin
      s1_color_d  = rd_color;
      s1_bright_d = bright_q;
      s1_valid_d  = pix_valid_i;
      valid2_d    = s1_valid_q;
      red_d       = red_q;
      green_d     = green_q;
      blue_d      = blue_q;
      if (s1_valid_q) begin
         red_d   = scale(s1_color_q[2*CH_W +: CH_W], s1_bright_q);
         green_d = scale(s1_color_q[CH_W   +: CH_W], s1_bright_q);
         blue_d  = scale(s1_color_q[0      +: CH_W], s1_bright_q);
      end
   end

   // fade and pipeline registers
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         bright_q    <= BR_FULL;
         dir_q       <= 1'b0;
         rate_q      <= 4'd1;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         wr_ready_q  <= 1'b0;
         s1_color_q  <= '0;
         s1_bright_q <= '0;
         s1_valid_q  <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         valid2_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bright_q    <= bright_d;
         dir_q       <= dir_d;
         rate_q      <= rate_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         wr_ready_q  <= wr_ready_d;
         s1_color_q  <= s1_color_d;
         s1_bright_q <= s1_bright_d;
         s1_valid_q  <= s1_valid_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         valid2_q    <= valid2_d;
      end
   end

   assign wr_ready_o   = wr_ready_q;
   assign red_o        = red_q;
   assign green_o      = green_q;
   assign blue_o       = blue_q;
   assign pix_valid_o  = valid2_q;
   assign fade_busy_o  = busy_q;
   assign brightness_o = bright_q;

endmodule

// File: tb/tb_palette_fade_lut.sv
// Directed bench for palette_fade_lut: reset state, read latency,
// read-before-write, fade stepping and truncation, write blocking, reset abort.
module tb_palette_fade_lut;

   localparam logic [383:0] INIT_PAL = (384'hA5C << (3*12)) |
                                       (384'hFFF << (5*12)) |
                                       (384'hF81 << (6*12));

   logic        Clk;
   logic        Reset_n;
   logic        pix_valid_i;
   logic [4:0]  pix_index_i;
   logic        vsync_i;
   logic        wr_valid_i;
   logic        wr_ready_o;
   logic [4:0]  wr_index_i;
   logic [11:0] wr_color_i;
   logic        swap_i;
   logic        fade_start_i;
   logic        fade_dir_i;
   logic [3:0]  fade_rate_i;
   logic [3:0]  red_o, green_o, blue_o;
   logic        pix_valid_o;
   logic        fade_busy_o;
   logic [4:0]  brightness_o;

   int n_checks = 0;
   int n_errors = 0;

   palette_fade_lut #(
      .IDX_W(5),
      .CH_W(4),
      .BRIGHT_W(4),
      .INIT_PALETTE(INIT_PAL)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .pix_valid_i(pix_valid_i),
      .pix_index_i(pix_index_i),
      .vsync_i(vsync_i),
      .wr_valid_i(wr_valid_i),
      .wr_ready_o(wr_ready_o),
      .wr_index_i(wr_index_i),
      .wr_color_i(wr_color_i),
      .swap_i(swap_i),
      .fade_start_i(fade_start_i),
      .fade_dir_i(fade_dir_i),
      .fade_rate_i(fade_rate_i),
      .red_o(red_o),
      .green_o(green_o),
      .blue_o(blue_o),
      .pix_valid_o(pix_valid_o),
      .fade_busy_o(fade_busy_o),
      .brightness_o(brightness_o)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic vsync_pulses(input int n);
      for (int k = 0; k < n; k++) begin
         vsync_i = 1'b1;
         tick();
         vsync_i = 1'b0;
         tick();
      end
   endtask

   function automatic logic [15:0] rgb();
      return {4'h0, red_o, green_o, blue_o};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset_n      = 1'b0;
      pix_valid_i  = 1'b0;
      pix_index_i  = '0;
      vsync_i      = 1'b0;
      wr_valid_i   = 1'b0;
      wr_index_i   = '0;
      wr_color_i   = '0;
      swap_i       = 1'b0;
      fade_start_i = 1'b0;
      fade_dir_i   = 1'b0;
      fade_rate_i  = '0;
      tick();
      tick();

      // reset state
      check("rst_bright", 16'(brightness_o), 16'd16);
      check("rst_busy", 16'(fade_busy_o), 16'd0);
      check("rst_pvalid", 16'(pix_valid_o), 16'd0);
      check("rst_rgb", rgb(), 16'h000);
      check("rst_wready", 16'(wr_ready_o), 16'd0);
      Reset_n = 1'b1;
      tick();
      check("wready_rise", 16'(wr_ready_o), 16'd1);

      // INIT entry 3 read, latency 2, then hold
      pix_valid_i = 1'b1; pix_index_i = 5'd3;
      tick();
      pix_valid_i = 1'b0;
      tick();
      check("init3_valid", 16'(pix_valid_o), 16'd1);
      check("init3_rgb", rgb(), 16'hA5C);
      tick();
      check("hold_valid", 16'(pix_valid_o), 16'd0);
      check("hold_rgb", rgb(), 16'hA5C);

      // read-before-write on index 7
      wr_valid_i = 1'b1; wr_index_i = 5'd7; wr_color_i = 12'h123;
      pix_valid_i = 1'b1; pix_index_i = 5'd7;
      tick();
      wr_valid_i = 1'b0;
      tick();
      pix_valid_i = 1'b0;
      check("rbw_old", rgb(), 16'h000);
      check("rbw_old_valid", 16'(pix_valid_o), 16'd1);
      tick();
      check("rbw_new", rgb(), 16'h123);

      // fade to black at rate 2
      fade_start_i = 1'b1; fade_dir_i = 1'b0; fade_rate_i = 4'd2;
      tick();
      fade_start_i = 1'b0;
      check("fade_busy", 16'(fade_busy_o), 16'd1);
      check("fade_wready", 16'(wr_ready_o), 16'd0);
      check("fade_b0", 16'(brightness_o), 16'd16);
      vsync_pulses(1);
      check("fade_1vs", 16'(brightness_o), 16'd16);
      vsync_pulses(1);
      check("fade_2vs", 16'(brightness_o), 16'd15);
      vsync_pulses(14);
      check("fade_16vs", 16'(brightness_o), 16'd8);

      // truncation at brightness 8 and write blocked while busy
      wr_valid_i = 1'b1; wr_index_i = 5'd6; wr_color_i = 12'h000;
      pix_valid_i = 1'b1; pix_index_i = 5'd6;
      check("busy_wready", 16'(wr_ready_o), 16'd0);
      tick();
      wr_valid_i = 1'b0;
      tick();
      check("trunc_rgb", rgb(), 16'h740);
      pix_valid_i = 1'b0;
      tick();
      check("blocked_wr_rgb", rgb(), 16'h740);

      // start while busy must be ignored
      fade_start_i = 1'b1; fade_dir_i = 1'b1; fade_rate_i = 4'd1;
      tick();
      fade_start_i = 1'b0;
      vsync_pulses(14);
      check("fade_30vs", 16'(brightness_o), 16'd1);
      vsync_pulses(1);
      check("fade_31vs", 16'(brightness_o), 16'd1);
      check("fade_31_busy", 16'(fade_busy_o), 16'd1);
      vsync_i = 1'b1;
      tick();
      vsync_i = 1'b0;
      check("pre_step_busy", 16'(fade_busy_o), 16'd1);
      check("pre_step_b", 16'(brightness_o), 16'd1);
      tick();
      check("end_b", 16'(brightness_o), 16'd0);
      check("end_busy", 16'(fade_busy_o), 16'd0);
      check("end_wready", 16'(wr_ready_o), 16'd1);

      // entry F/F/F at brightness 0
      pix_valid_i = 1'b1; pix_index_i = 5'd5;
      tick();
      pix_valid_i = 1'b0;
      tick();
      check("black_rgb", rgb(), 16'h000);
      check("black_valid", 16'(pix_valid_o), 16'd1);

      // fade up with rate 0 (steps every vsync)
      fade_start_i = 1'b1; fade_dir_i = 1'b1; fade_rate_i = 4'd0;
      tick();
      fade_start_i = 1'b0;
      check("up_busy", 16'(fade_busy_o), 16'd1);
      vsync_pulses(1);
      check("up_1vs", 16'(brightness_o), 16'd1);
      vsync_pulses(15);
      check("up_16vs", 16'(brightness_o), 16'd16);
      check("up_done_busy", 16'(fade_busy_o), 16'd0);

      // fade up when already full: no busy
      fade_start_i = 1'b1; fade_dir_i = 1'b1; fade_rate_i = 4'd3;
      tick();
      fade_start_i = 1'b0;
      check("noop_busy", 16'(fade_busy_o), 16'd0);
      check("noop_wready", 16'(wr_ready_o), 16'd1);
      vsync_pulses(3);
      check("noop_bright", 16'(brightness_o), 16'd16);

      // overwrite entry 3, then reset mid-fade at brightness 5
      wr_valid_i = 1'b1; wr_index_i = 5'd3; wr_color_i = 12'h111;
      tick();
      wr_valid_i = 1'b0;
      fade_start_i = 1'b1; fade_dir_i = 1'b0; fade_rate_i = 4'd1;
      tick();
      fade_start_i = 1'b0;
      vsync_pulses(11);
      check("mid_bright", 16'(brightness_o), 16'd5);
      pix_valid_i = 1'b1; pix_index_i = 5'd3;
      tick();
      tick();
      check("mid_pvalid", 16'(pix_valid_o), 16'd1);
      Reset_n = 1'b0;
      tick();
      check("abort_bright", 16'(brightness_o), 16'd16);
      check("abort_busy", 16'(fade_busy_o), 16'd0);
      check("abort_pvalid", 16'(pix_valid_o), 16'd0);
      check("abort_wready", 16'(wr_ready_o), 16'd0);
      Reset_n = 1'b1;
      tick();
      pix_valid_i = 1'b0;
      tick();
      check("abort_init_rgb", rgb(), 16'hA5C);
      check("abort_init_valid", 16'(pix_valid_o), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
